// File: rtl/temporal_pkg.sv
// temporal_pkg: shared defaults, value-width helper and pending-buffer state for temporal stages
package temporal_pkg;
  localparam int GAMMA_CYCLE_WIDTH_DEF = 16;
  localparam int PULSE_WIDTH_DEF = 8;
  function automatic int val_w(input int g);
    return $clog2(g);
  endfunction
  typedef enum logic {EMPTY, FULL} pend_t;
endpackage

// File: rtl/gamma_counter.sv
// gamma_counter: free-running gamma-cycle counter with registered start/boundary flags
// Ports: clk, rst_n (async active-low); cnt current position, cnt_nxt value after the next edge,
// run high from the first edge after reset, start high at cnt 0, boundary high at the last count.
module gamma_counter import temporal_pkg::*; #(
  parameter int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
  localparam int VAL_W = val_w(GAMMA_CYCLE_WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [VAL_W-1:0] cnt,
  output logic [VAL_W-1:0] cnt_nxt,
  output logic             run,
  output logic             start,
  output logic             boundary
);
  localparam logic [VAL_W-1:0] LAST = VAL_W'(GAMMA_CYCLE_WIDTH - 1);
  // The first edge after reset holds the count at 0 so that edge opens gamma cycle 0.
  assign cnt_nxt = !run ? '0 : cnt == LAST ? '0 : cnt + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
      start <= 1'b0;
      boundary <= 1'b0;
    end else begin
      run <= 1'b1;
      cnt <= cnt_nxt;
      start <= cnt_nxt == '0;
      boundary <= cnt_nxt == LAST;
    end
endmodule

// File: rtl/temporal_encoder.sv
// temporal_encoder: turns per-channel spike times into pulses aligned to a gamma cycle
// Ports: aclk, grst_n (async active-low); in_valid/in_ready/in_val/in_null input bundle handshake;
// out_pulse per-channel spikes; gamma_rst boundary latch reset; gamma_start cycle-0 flag; gamma_cnt position.
module temporal_encoder import temporal_pkg::*; #(
  parameter int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
  parameter int PULSE_WIDTH = PULSE_WIDTH_DEF,
  parameter int N_CH = 2,
  localparam int VAL_W = val_w(GAMMA_CYCLE_WIDTH)
) (
  input  logic                       aclk,
  input  logic                       grst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_CH-1:0][VAL_W-1:0] in_val,
  input  logic [N_CH-1:0]            in_null,
  output logic [N_CH-1:0]            out_pulse,
  output logic                       gamma_rst,
  output logic                       gamma_start,
  output logic [VAL_W-1:0]           gamma_cnt
);
  localparam logic [VAL_W:0] LAST = (VAL_W+1)'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [VAL_W:0] PW = (VAL_W+1)'(PULSE_WIDTH);
  logic [VAL_W-1:0] cnt_nxt;
  logic run, accept, take_new;
  pend_t pend;
  logic [N_CH-1:0][VAL_W-1:0] pend_val, act_val, act_val_nxt;
  logic [N_CH-1:0] pend_null, act_null, act_null_nxt, new_null, pulse_nxt;
  gamma_counter #(.GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH)) u_gc (
    .clk(aclk),
    .rst_n(grst_n),
    .cnt(gamma_cnt),
    .cnt_nxt(cnt_nxt),
    .run(run),
    .start(gamma_start),
    .boundary(gamma_rst)
  );
  // gamma_rst is the registered boundary flag, so it marks the current cycle as the boundary.
  assign in_ready = run && (pend == EMPTY || gamma_rst);
  assign accept = in_valid && in_ready;
  // An acceptance into an empty buffer on the boundary bypasses pending straight into active.
  assign take_new = accept && !(gamma_rst && pend == EMPTY);
  assign act_val_nxt = !gamma_rst ? act_val : pend == FULL ? pend_val : in_val;
  assign act_null_nxt = !gamma_rst ? act_null : pend == FULL ? pend_null : accept ? new_null : '1;
  // Pulses are computed from next-cycle state so out_pulse can be a plain flop aligned with gamma_cnt.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign new_null[g] = in_null[g] || {1'b0, in_val[g]} >= LAST;
    assign pulse_nxt[g] = !act_null_nxt[g] && act_val_nxt[g] <= cnt_nxt &&
                          {1'b0, cnt_nxt} < {1'b0, act_val_nxt[g]} + PW && {1'b0, cnt_nxt} != LAST;
  end
  always_ff @(posedge aclk or negedge grst_n)
    if (!grst_n) begin
      pend <= EMPTY;
      pend_val <= '0;
      pend_null <= '1;
      act_val <= '0;
      act_null <= '1;
      out_pulse <= '0;
    end else begin
      pend <= take_new ? FULL : gamma_rst ? EMPTY : pend;
      pend_val <= take_new ? in_val : pend_val;
      pend_null <= take_new ? new_null : pend_null;
      act_val <= act_val_nxt;
      act_null <= act_null_nxt;
      out_pulse <= pulse_nxt;
    end
endmodule

// File: tb/tb_temporal_encoder.sv
// tb_temporal_encoder: directed plus random checks of temporal_encoder against a queue-based reference
module tb_temporal_encoder;
  logic aclk = 1'b0, grst_n = 1'b0, in_valid = 1'b0;
  logic in_ready, gamma_rst, gamma_start;
  logic [1:0][3:0] in_val = '0;
  logic [1:0] in_null = '0, out_pulse;
  logic [3:0] gamma_cnt;
  int total = 0, bad = 0;
  typedef struct {int c0; int c1;} bnd_t;
  bnd_t q[$];
  bnd_t act = '{-1, -1};
  int m_cnt = 0, acc_cnt = 0, hi0 = 0, hi1 = 0, nrst = 0, at = 0;
  bit m_run = 0, acc = 0;
  logic ge_q, a_seen;

  always #5 aclk = ~aclk;

  temporal_encoder dut (
    .aclk(aclk), .grst_n(grst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_val(in_val), .in_null(in_null), .out_pulse(out_pulse),
    .gamma_rst(gamma_rst), .gamma_start(gamma_start), .gamma_cnt(gamma_cnt)
  );

  // Downstream greater_than_eq stand-in: a is ch0, b is ch1; q sets when b arrives no later than a.
  always_ff @(posedge aclk or negedge grst_n)
    if (!grst_n) begin
      ge_q <= 1'b0;
      a_seen <= 1'b0;
    end else if (gamma_rst) begin
      ge_q <= 1'b0;
      a_seen <= 1'b0;
    end else begin
      if (out_pulse[1] && !a_seen) ge_q <= 1'b1;
      if (out_pulse[0]) a_seen <= 1'b1;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int v, input bit n);
    return (n || v >= 15) ? -1 : v;
  endfunction

  function automatic logic pbit(input int v);
    return v >= 0 && v <= m_cnt && m_cnt < v + 8 && m_cnt < 15;
  endfunction

  task automatic tick();
    bnd_t b;
    bit exp_ready;
    @(negedge aclk);
    exp_ready = m_run && (q.size() == 0 || m_cnt == 15);
    chk("in_ready", in_ready, exp_ready);
    acc = in_valid && exp_ready;
    acc_cnt = m_cnt;
    b.c0 = eff(int'(in_val[0]), in_null[0]);
    b.c1 = eff(int'(in_val[1]), in_null[1]);
    @(posedge aclk);
    #1;
    if (!m_run) begin
      m_run = 1;
      m_cnt = 0;
    end else begin
      if (acc) q.push_back(b);
      if (m_cnt == 15) begin
        if (q.size() > 0) act = q.pop_front();
        else act = '{-1, -1};
      end
      m_cnt = (m_cnt + 1) % 16;
    end
    hi0 += int'(out_pulse[0]);
    hi1 += int'(out_pulse[1]);
    nrst += int'(gamma_rst);
    chk("gamma_cnt", gamma_cnt, m_cnt);
    chk("gamma_start", gamma_start, m_cnt == 0);
    chk("gamma_rst", gamma_rst, m_cnt == 15);
    chk("out_pulse", out_pulse, {pbit(act.c1), pbit(act.c0)});
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic to_cnt(input int c);
    for (int k = 0; k < 40 && m_cnt != c; k++) tick();
  endtask

  task automatic send(input int v0, input int v1, input bit n0, input bit n1, output int when);
    in_valid = 1'b1;
    in_val[0] = 4'(v0);
    in_val[1] = 4'(v1);
    in_null = {n1, n0};
    when = -1;
    for (int k = 0; k < 40 && when < 0; k++) begin
      tick();
      if (acc) when = acc_cnt;
    end
    chk("accept_in_time", when >= 0, 1'b1);
  endtask

  task automatic zero_hi();
    hi0 = 0;
    hi1 = 0;
    nrst = 0;
  endtask

  task automatic reset_now();
    grst_n = 1'b0;
    #1;
    chk("rst_cnt", gamma_cnt, 0);
    chk("rst_pulse", out_pulse, 0);
    chk("rst_grst", gamma_rst, 0);
    chk("rst_start", gamma_start, 0);
    chk("rst_ready", in_ready, 0);
    m_run = 0;
    m_cnt = 0;
    q.delete();
    act = '{-1, -1};
    repeat (2) @(posedge aclk);
    #2 grst_n = 1'b1;
  endtask

  initial begin
    int a, b;
    reset_now();
    run(2);
    // basic spikes
    send(3, 5, 0, 0, at);
    in_valid = 1'b0;
    zero_hi();
    run(32);
    chk("basic_hi0", hi0, 8);
    chk("basic_hi1", hi1, 8);
    // clipping and null
    send(12, 15, 0, 0, at);
    in_valid = 1'b0;
    zero_hi();
    run(32);
    chk("clip_hi0", hi0, 3);
    chk("null15_hi1", hi1, 0);
    send(0, 4, 1, 0, at);
    in_valid = 1'b0;
    zero_hi();
    run(32);
    chk("nullflag_hi0", hi0, 0);
    chk("null_other_hi1", hi1, 8);
    // back-to-back offers
    to_cnt(2);
    send(1, 2, 0, 0, at);
    chk("b2b_a_at", at, 2);
    send(6, 9, 0, 0, at);
    chk("b2b_b_at", at, 15);
    in_valid = 1'b0;
    zero_hi();
    run(16);
    chk("b2b_a_hi0", hi0, 8);
    chk("b2b_a_hi1", hi1, 8);
    zero_hi();
    run(16);
    chk("b2b_b_hi0", hi0, 8);
    chk("b2b_b_hi1", hi1, 6);
    // empty pending gamma
    zero_hi();
    run(16);
    chk("empty_hi", hi0 + hi1, 0);
    chk("empty_nrst", nrst, 1);
    // reset mid-pulse
    send(2, 0, 0, 1, at);
    in_valid = 1'b0;
    to_cnt(15);
    tick();
    to_cnt(6);
    chk("pre_reset_pulse", out_pulse[0], 1'b1);
    reset_now();
    zero_hi();
    run(16);
    chk("post_reset_hi", hi0 + hi1, 0);
    // downstream greater_than_eq integration
    for (int k = 0; k < 2; k++) begin
      a = k == 0 ? 3 : 5;
      b = k == 0 ? 5 : 3;
      send(a, b, 0, 0, at);
      in_valid = 1'b0;
      to_cnt(15);
      tick();
      to_cnt(14);
      chk("ge_q", ge_q, a >= b);
    end
    // random traffic
    for (int k = 0; k < 400; k++) begin
      in_valid = $urandom_range(0, 2) == 0;
      in_val[0] = 4'($urandom_range(0, 15));
      in_val[1] = 4'($urandom_range(0, 15));
      in_null = 2'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
      tick();
    end
    in_valid = 1'b0;
    run(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/temporal_encoder.md
TEMPORAL_ENCODER -- requirements
Module: temporal_encoder

Interface
REQ-001 Parameter GAMMA_CYCLE_WIDTH, default 16: aclk cycles per gamma cycle; legal values are 4 or more.
REQ-002 Parameter PULSE_WIDTH, default 8: nominal spike length in aclk cycles; legal range is 1 to GAMMA_CYCLE_WIDTH-1.
REQ-003 Parameter N_CH, default 2: number of spike output channels.
REQ-004 Derived constant VAL_W = $clog2(GAMMA_CYCLE_WIDTH).
REQ-005 Ports:
- aclk  in  1  block clock.
- grst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input value bundle offered.
- in_ready  out  1  input bundle accepted when in_valid and in_ready are both high.
- in_val  in  N_CH x VAL_W  spike time per channel.
- in_null  in  N_CH  per-channel "no spike" flag.
- out_pulse  out  N_CH  temporally encoded spikes, which feed greater_than_eq a/b.
- gamma_rst  out  1  downstream latch reset (rst).
- gamma_start  out  1  high during gamma cycle 0.
- gamma_cnt  out  VAL_W  current gamma cycle position.

Function
REQ-006 The gamma counter shall run continuously from 0 to GAMMA_CYCLE_WIDTH-1, then wrap to 0; gamma_cnt presents its value.
REQ-007 The boundary cycle is the cycle in which gamma_cnt equals GAMMA_CYCLE_WIDTH-1.
REQ-008 gamma_rst shall be high exactly in the boundary cycle; gamma_start shall be high exactly when gamma_cnt is 0.
REQ-009 The block shall hold a one-entry pending buffer (state EMPTY or FULL) and one active register.
REQ-010 in_ready shall be high when the pending buffer is EMPTY, or when it is FULL and the current cycle is the boundary cycle.
REQ-011 At the end of the boundary cycle:
- FULL: the pending contents move to active;
- EMPTY: active becomes all-null.
REQ-012 A transfer and an acceptance in the same boundary cycle shall both occur: the old entry goes to active, the new entry goes to pending, and pending stays FULL.
REQ-013 An accepted bundle shall be emitted in the first gamma cycle that starts after acceptance, including acceptance during a boundary cycle while pending is EMPTY.
REQ-014 out_pulse[i] shall be high in a cycle iff all of the following hold:
- active channel i is non-null;
- active_val[i] <= gamma_cnt < active_val[i]+PULSE_WIDTH;
- gamma_cnt < GAMMA_CYCLE_WIDTH-1.
REQ-015 An in_val greater than or equal to GAMMA_CYCLE_WIDTH-1 shall be treated as null.
REQ-016 The comparison sum in REQ-014 shall be computed at VAL_W+1 bits so it cannot wrap.
REQ-017 Pulses shall be clipped so that every out_pulse bit is low in every boundary cycle, guaranteeing that gamma_rst never overlaps a spike.
REQ-018 All outputs shall be driven directly from flops, with no combinational path from inputs to out_pulse, gamma_rst or gamma_start.
REQ-019 in_ready may be combinational from state and counter only; it shall not depend on in_valid.

Reset
REQ-020 While grst_n is low, all of the following shall hold immediately, without waiting for a clock edge:
- gamma_cnt = 0;
- pending = EMPTY;
- active all-null;
- out_pulse = 0, gamma_rst = 0, gamma_start = 0, in_ready = 0.
REQ-021 On the first aclk edge after grst_n rises: gamma_cnt = 0, gamma_start = 1, in_ready = 1.
REQ-022 A reset in mid-gamma shall discard the active and pending entries; no partial pulse shall resume after reset.

Structure
REQ-023 A shared package temporal_pkg shall hold:
- the default GAMMA_CYCLE_WIDTH and PULSE_WIDTH;
- the VAL_W derivation function;
- the pending-buffer state enum (EMPTY, FULL).
REQ-024 The counter, boundary decode and gamma_rst/gamma_start flops shall live in the sub-module gamma_counter, which the team reuses across temporal stages.
REQ-025 The per-channel window compare shall be a generate loop over N_CH inside temporal_encoder.

Verification
REQ-026 The bench shall cover the following directed scenarios, all with GAMMA_CYCLE_WIDTH=16, PULSE_WIDTH=8, N_CH=2:
- Basic spikes: accept ch0=3, ch1=5 during gamma k -> in gamma k+1, ch0 high at cnt 3..10, ch1 high at cnt 5..12; gamma_rst high only at cnt 15.
- Clipping and null values: ch0=12, ch1=15 -> ch0 high at cnt 12..14, low at cnt 15; ch1 never high; in_null=1 with ch0=0 also gives no pulse.
- Back-to-back offers: in_valid held with bundles A then B -> A accepted at once; in_ready low until cnt 15; B accepted at cnt 15; A emitted next gamma, B the gamma after.
- Empty pending: no input offered for a gamma -> out_pulse all 0 through that gamma; gamma_rst still pulses at cnt 15.
- Reset mid-pulse: ch0=2 active, grst_n low at cnt 6 -> out_pulse 0 immediately; after release gamma_cnt restarts at 0, no spike that gamma, in_ready = 1.
- Integration with greater_than_eq, whose rst is driven by gamma_rst: feed ch0=3 as a and ch1=5 as b -> downstream q behaves as a>=b false per that stage's encoding; feed ch0=5 and ch1=3 -> the true case.
